// File: rtl/fpu_add_arbiter_if.sv
// fpu_add_arbiter_if: requester and response channel bundle for the shared FP adder
interface fpu_add_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2
);
  logic [NUM_REQ-1:0] req_valid;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0] req_ready;
  logic resp_valid;
  logic resp_ready;
  logic [31:0] resp_sum;
  logic [ID_W-1:0] resp_id;
  logic [15:0] op_count;
  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input req_ready, resp_valid, resp_sum, resp_id, op_count
  );
  modport slave (
    input req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_sum, resp_id, op_count
  );
endinterface

// File: rtl/fpu_add_arbiter.sv
// fpu_add_arbiter: round-robin sharing of one FP adder across requesters; FPU_ARB_OPCOUNT_EN adds an op counter
module adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);
  logic [31:0] x, y;
  logic [8:0] ex, ey, d, lz, sft, e, ef;
  logic [26:0] mx, my, sh, n;
  logic [27:0] s;
  logic [24:0] r;
  always_comb begin
    {x, y} = (a[30:0] >= b[30:0]) ? {a, b} : {b, a};
    ex = (x[30:23] == 8'd0) ? 9'd1 : {1'b0, x[30:23]};
    ey = (y[30:23] == 8'd0) ? 9'd1 : {1'b0, y[30:23]};
    mx = {x[30:23] != 8'd0, x[22:0], 3'b000};
    my = {y[30:23] != 8'd0, y[22:0], 3'b000};
    d = ex - ey;
    sh = (d > 9'd26) ? {26'd0, |my} : (my >> d) | {26'd0, |(my & ~(27'h7FFFFFF << d))};
    s = (x[31] == y[31]) ? {1'b0, mx} + {1'b0, sh} : {1'b0, mx} - {1'b0, sh};
    lz = 9'd27;
    for (int i = 0; i < 27; i++) lz = s[i] ? 9'(26 - i) : lz;
    sft = (lz > ex - 9'd1) ? ex - 9'd1 : lz;
    n = s[27] ? {s[27:2], s[1] | s[0]} : s[26:0] << sft;
    e = s[27] ? ex + 9'd1 : ex - sft;
    r = {1'b0, n[26:3]} + {24'd0, n[2] & (n[1] | n[0] | n[3])};
    ef = (r[24] | r[23]) ? e + {8'd0, r[24]} : 9'd0;
    sum = (x[30:23] == 8'hFF) ? (((x[22:0] != 23'd0) || (y[30:0] == x[30:0] && x[31] != y[31])) ? 32'h7FC00000 : x)
        : (s == 28'd0) ? {x[31] & y[31], 31'd0}
        : (ef >= 9'd255) ? {x[31], 8'hFF, 23'd0}
        : {x[31], ef[7:0], r[24] ? r[23:1] : r[22:0]};
  end
endmodule

module fpu_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2
) (
  input logic clk,
  input logic rst,
  fpu_add_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_n;
  logic [ID_W-1:0] last_grant, w, id_r;
  logic any, take, hs;
  logic [31:0] op_a, op_b, add_sum;
  adder u_adder (.a(op_a), .b(op_b), .sum(add_sum));
  always_comb begin
    w = '0;
    any = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (bus.req_valid[(int'(last_grant) + k) % NUM_REQ]) begin
        w = ID_W'((int'(last_grant) + k) % NUM_REQ);
        any = 1'b1;
      end
    end
  end
  assign take = state == IDLE && any && !rst;
  assign hs = bus.resp_valid && bus.resp_ready;
  assign bus.req_ready = take ? {{(NUM_REQ-1){1'b0}}, 1'b1} << w : '0;
  always_comb state_n = (state == IDLE) ? (any ? EXEC : IDLE) : (state == EXEC) ? RESP : (hs ? IDLE : RESP);
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= ID_W'(NUM_REQ - 1);
      op_a <= '0;
      op_b <= '0;
      id_r <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_sum <= '0;
      bus.resp_id <= '0;
    end else begin
      if (take) begin
        op_a <= bus.req_a[32*w +: 32];
        op_b <= bus.req_b[32*w +: 32];
        id_r <= w;
        last_grant <= w;
      end
      if (state == EXEC) begin
        bus.resp_sum <= add_sum;
        bus.resp_id <= id_r;
        bus.resp_valid <= 1'b1;
      end else if (hs) begin
        bus.resp_valid <= 1'b0;
      end
    end
  end
`ifdef FPU_ARB_OPCOUNT_EN
  logic [15:0] cnt;
  always_ff @(posedge clk) cnt <= rst ? 16'd0 : cnt + {15'd0, hs};
  assign bus.op_count = cnt;
`else
  assign bus.op_count = 16'h0000;
`endif
endmodule

// File: tb/tb_fpu_add_arbiter.sv
// tb_fpu_add_arbiter: directed scoreboard bench for the shared-adder arbiter
module tb_fpu_add_arbiter;
  localparam int N = 4;
  localparam int W = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fpu_add_arbiter_if #(.NUM_REQ(N), .ID_W(W)) ifc ();
  fpu_add_arbiter #(.NUM_REQ(N), .ID_W(W)) dut (.clk(clk), .rst(rst), .bus(ifc));
  typedef struct packed {
    logic [W-1:0] id;
    logic [31:0] sum;
  } resp_t;
  resp_t sb[$];
  int gq[$];
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] pa[N] = '{default: 32'd0};
  logic [31:0] pb[N] = '{default: 32'd0};
  int issued[N] = '{default: 0};
  int done_n[N] = '{default: 0};
  int to_req = 0;
  logic end_flag = 1'b0;
  logic preload_req = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    logic [N-1:0] g;
    ifc.req_valid = '0;
    ifc.req_a = '0;
    ifc.req_b = '0;
    forever begin
      @(negedge clk);
      g = ifc.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (g[i]) done_n[i]++;
        ifc.req_valid[i] = issued[i] != done_n[i];
        ifc.req_a[32*i +: 32] = pa[i];
        ifc.req_b[32*i +: 32] = pb[i];
      end
    end
  end

  logic [15:0] exp_cnt = 16'd0;
  logic prev_rst = 1'b1, prev_hold = 1'b0, rose = 1'b0, end_seen = 1'b0, pre_st = 1'b0, rel_st = 1'b0;
  logic [31:0] h_sum = 32'd0;
  logic [W-1:0] h_id = '0;
  int cyc = 0, gcyc = 0, to_seen = 0, gi;
  resp_t e;
  always @(negedge clk) begin
    cyc++;
    chk("req_ready_onehot", {31'd0, $onehot0(ifc.req_ready)}, 32'd1);
    if (rst) begin
      chk("rst_resp_valid", {31'd0, ifc.resp_valid}, 32'd0);
      chk("rst_req_ready", 32'(ifc.req_ready), 32'd0);
    end else begin
      if (prev_rst) begin
        chk("rst_resp_sum", ifc.resp_sum, 32'd0);
        chk("rst_resp_id", 32'(ifc.resp_id), 32'd0);
      end
      if (prev_hold) begin
        chk("hold_valid", {31'd0, ifc.resp_valid}, 32'd1);
        chk("hold_sum", ifc.resp_sum, h_sum);
        chk("hold_id", 32'(ifc.resp_id), 32'(h_id));
        chk("hold_req_ready", 32'(ifc.req_ready), 32'd0);
      end
      if (ifc.req_ready != '0) begin
        gi = 0;
        for (int i = 0; i < N; i++) if (ifc.req_ready[i]) gi = i;
        chk("grant_expected", 32'(gq.size() != 0), 32'd1);
        if (gq.size() != 0) chk("grant_id", 32'(gi), 32'(gq.pop_front()));
        gcyc = cyc;
      end
      if (ifc.resp_valid && !rose) chk("latency", 32'(cyc - gcyc), 32'd2);
      if (ifc.resp_valid && ifc.resp_ready) begin
        chk("resp_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("resp_id", 32'(ifc.resp_id), 32'(e.id));
          chk("resp_sum", ifc.resp_sum, e.sum);
        end
      end
    end
`ifdef FPU_ARB_OPCOUNT_EN
    chk("op_count", 32'(ifc.op_count), 32'(exp_cnt));
`else
    chk("op_count", 32'(ifc.op_count), 32'd0);
`endif
    exp_cnt = rst ? 16'd0 : exp_cnt + 16'(ifc.resp_valid && ifc.resp_ready);
`ifdef FPU_ARB_OPCOUNT_EN
    if (preload_req && !pre_st) begin
      force dut.cnt = 16'hFFFF;
      exp_cnt = 16'hFFFF;
      pre_st = 1'b1;
    end else if (pre_st && !rel_st) begin
      release dut.cnt;
      rel_st = 1'b1;
    end
`endif
    rose = ifc.resp_valid && !ifc.resp_ready && !rst;
    prev_hold = rose;
    h_sum = ifc.resp_sum;
    h_id = ifc.resp_id;
    prev_rst = rst;
    if (to_req != to_seen) begin
      chk("wait_bound", 32'(to_seen), 32'(to_req));
      to_seen = to_req;
    end
    if (end_flag && !end_seen) begin
      chk("sb_drain", 32'(sb.size()), 32'd0);
      chk("grant_drain", 32'(gq.size()), 32'd0);
      end_seen = 1'b1;
    end
  end

  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b, input int n);
    pa[i] = a;
    pb[i] = b;
    issued[i] += n;
  endtask

  task automatic expect_op(input int i, input logic [31:0] s);
    gq.push_back(i);
    sb.push_back(resp_t'{W'(i), s});
  endtask

  function automatic logic quiet();
    quiet = gq.size() == 0 && sb.size() == 0;
    for (int i = 0; i < N; i++) if (issued[i] != done_n[i]) quiet = 1'b0;
  endfunction

  task automatic wait_quiet();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (quiet()) return;
    end
    to_req++;
  endtask

  task automatic pulse_rst();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic seen;
    ifc.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    expect_op(0, 32'h41500000);
    issue(0, 32'h412C0000, 32'h40100000, 1);
    wait_quiet();
    expect_op(2, 32'hC4167000);
    issue(2, 32'hC348E000, 32'hC3C87000, 1);
    wait_quiet();
    pulse_rst();
    @(negedge clk);
    for (int i = 0; i < 4; i++) expect_op(i, 32'h40000000);
    expect_op(0, 32'h40000000);
    issue(0, 32'h3F800000, 32'h3F800000, 2);
    for (int i = 1; i < 4; i++) issue(i, 32'h3F800000, 32'h3F800000, 1);
    wait_quiet();
    ifc.resp_ready = 1'b0;
    expect_op(1, 32'h40600000);
    expect_op(3, 32'h00000000);
    issue(1, 32'h40400000, 32'h3F000000, 1);
    issue(3, 32'h3F800000, 32'hBF800000, 1);
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      seen = ifc.resp_valid;
    end
    if (!seen) to_req++;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1 ifc.resp_ready = 1'b1;
    wait_quiet();
    @(negedge clk);
    gq.push_back(1);
    issue(1, 32'h3F800000, 32'h40000000, 1);
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      seen = ifc.req_ready[1];
    end
    if (!seen) to_req++;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    expect_op(0, 32'h40700000);
    expect_op(1, 32'h40400000);
    issue(1, 32'h3F800000, 32'h40000000, 1);
    issue(0, 32'h3FC00000, 32'h40100000, 1);
    wait_quiet();
    for (int k = 0; k < 3; k++) begin
      expect_op(2, 32'h40000000);
      issue(2, 32'h3F800000, 32'h3F800000, 1);
      wait_quiet();
    end
`ifdef FPU_ARB_OPCOUNT_EN
    preload_req = 1'b1;
    repeat (3) @(negedge clk);
    expect_op(3, 32'h40000000);
    issue(3, 32'h3F800000, 32'h3F800000, 1);
    wait_quiet();
`endif
    repeat (2) @(negedge clk);
    end_flag = 1'b1;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: run still active after 20000 cycles");
    $fatal(1);
  end
endmodule
